op2_gather: RTL and testbench
=============================

Name: op2_gather

Overview:
- Front end for the second-stage 16-input adder.
- Accepts a serial stream of 12-bit partial results over a valid/ready handshake and gathers them into one frame of 16 parallel words.
- Presents the frame on a flat bus that feeds the adder's data0..data15 inputs, and holds it under a valid/ready handshake until the downstream stage takes it.
- It is the producer side of the adder's parallel-input interface.

Parameters:
- DATA_W, 12, width of each word/slot.
- NUM, 16, slots per frame; fixed at 16 in this design; count width 4.

Ports:
- clock  in  1  single system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous clear; discards any partial or held frame.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts in_data this cycle.
- in_data  in  DATA_W  serial input word.
- out_valid  out  1  data_out holds a complete frame.
- out_ready  in  1  downstream accepts the frame.
- data_out  out  DATA_W*NUM  flat frame; slot i = bits [12i+11:12i]; slot i maps to adder input data<i>.
- fill_level  out  5  words captured in the current fill frame, 0..16.

Behaviour:
- Input transfer: in_valid && in_ready at a rising edge. Output transfer: out_valid && out_ready at a rising edge.
- Reset (async assert, sync release):
  - state FILL, count 0.
  - out_valid 0, data_out all 0, fill_level 0.
  - in_ready 1 (combinational from state) once reset_n is high.
- State FILL:
  - in_ready = 1.
  - Each input transfer writes in_data into slot[count], then count++.
  - Slots are filled strictly in arrival order: the first word goes to slot 0.
  - The transfer that fills slot 15 moves to HOLD. count wraps to 0 and out_valid = 1 on the next cycle, so latency from the 16th accept to out_valid is 1 cycle.
- State HOLD:
  - in_ready = 0. out_valid = 1.
  - data_out is stable and must not change while out_valid = 1.
  - An output transfer returns to FILL with out_valid = 0 on the next cycle.
  - in_ready rises in that same next cycle, so there is 1 bubble cycle between frames.
- data_out while out_valid = 0 is don't-care for consumers. Slots are written in place during FILL, so partial contents are visible.
- fill_level = count in FILL; 16 in HOLD.
- clear has the highest priority over all transfers in the same cycle:
  - next state FILL, count 0, out_valid 0.
  - data_out is not zeroed.
  - An input offered in the clear cycle is dropped, not captured.
- If in_valid and out_ready are asserted in the same HOLD cycle, only the output transfer happens; the input is not accepted because in_ready = 0.
- No arithmetic is performed. Words pass bit-exact; there is no sign handling.
- reset_n asserted mid-frame: all state returns to reset values immediately (asynchronous).

Optional Feature:
- Macro: OP2_GATHER_DBUF_EN.
- Defined:
  - A shadow bank of 16 slots plus a shadow count is added.
  - Filling always targets the shadow bank, and data_out is the output bank only.
  - Completing 16 shadow words when out_valid = 0 copies shadow to output, and out_valid = 1 next cycle.
  - Completing them when out_valid = 1 marks the shadow full; in_ready = 0 until an output transfer.
  - An output transfer while the shadow is full copies shadow to output in the same edge. out_valid stays 1 and in_ready = 1 next cycle.
  - In steady state there are 0 bubble cycles.
  - fill_level reports the shadow count (16 while shadow is full).
  - clear empties both banks.
- Undefined: single-bank behaviour as specified above.

Test Plan:
- Reset, then feed words 0x001..0x010 back-to-back with out_ready = 0 -> out_valid rises 1 cycle after the 16th accept; slot0 = 0x001, slot15 = 0x010; in_ready = 0; fill_level = 16.
- Hold out_ready = 0 for 10 cycles while in_valid = 1 -> data_out is unchanged and no input is accepted. Then pulse out_ready for 1 cycle -> out_valid = 0 and in_ready = 1 on the next cycle.
- Accept 7 words, assert clear together with in_valid = 1 -> fill_level = 0, that word is dropped; the next 16 words form a frame starting at slot 0.
- Random in_valid/out_ready, 1000 frames -> every frame matches the scoreboard in order; no loss or duplication; data_out is stable while out_valid = 1 and out_ready = 0.
- Assert reset_n low mid-HOLD, asynchronous to the clock -> out_valid = 0 and data_out = 0 without waiting for an edge.
- With OP2_GATHER_DBUF_EN, continuous input and out_ready = 1 -> a frame every 16 cycles with zero bubbles. With out_ready = 0, exactly 32 words are accepted before in_ready = 0.

Source files
------------

// File: rtl/op2_gather.sv
// op2_gather -- serial-to-parallel front end for the second-stage 16-input adder.
//
// Gathers a stream of DATA_W-bit partial results (valid/ready) into a frame of
// NUM parallel words. The complete frame is held on data_out under a
// valid/ready handshake until the adder stage takes it.
//
// Ports:
//   clock       system clock, rising edge
//   reset_n     asynchronous active-low reset
//   clear       synchronous clear; drops partial/held frame, wins over transfers
//   in_valid    in_data valid
//   in_ready    block accepts in_data this cycle
//   in_data     serial input word
//   out_valid   data_out holds a complete frame
//   out_ready   downstream takes the frame
//   data_out    flat frame, slot i = bits [DATA_W*i +: DATA_W] -> adder data<i>
//   fill_level  words captured in the frame being filled (16 when blocked)
//
// Build option: define OP2_GATHER_DBUF_EN to add a shadow fill bank so that a
// new frame can be gathered while the previous one is still held (no bubble).

module op2_gather_slot #(
    parameter int DATA_W = 12
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              load,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)  q <= '0;
        else if (load) q <= d;
    end
endmodule

module op2_gather #(
    parameter int DATA_W = 12,
    parameter int NUM    = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W*NUM-1:0] data_out,
    output logic [4:0]            fill_level
);
    logic            in_xfer;
    logic            out_xfer;
    logic            last_in;
    logic [3:0]      count;
    logic [NUM-1:0]  wr_sel;

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;
    assign last_in  = in_xfer && (count == 4'd15);

    // One-hot slot write enable; an input offered with clear is dropped.
    for (genvar i = 0; i < NUM; i++) begin : g_sel
        assign wr_sel[i] = in_xfer && !clear && (count == 4'(i));
    end

`ifdef OP2_GATHER_DBUF_EN

    logic [NUM-1:0][DATA_W-1:0] shadow;
    logic [NUM-1:0][DATA_W-1:0] obank;
    logic                       copy;
    logic                       ovalid;
    logic                       sfull;

    // Shadow -> output copy: either the shadow just completed and the output
    // bank is free (empty or leaving this edge), or a full shadow is waiting
    // and the held frame leaves. The 16th word is forwarded straight from
    // in_data since the shadow register only updates at the same edge.
    assign copy = !clear && ((last_in && (!ovalid || out_xfer)) || (sfull && out_xfer));

    for (genvar i = 0; i < NUM; i++) begin : g_lane
        op2_gather_slot #(.DATA_W(DATA_W)) u_shadow (
            .clock   (clock),
            .reset_n (reset_n),
            .load    (wr_sel[i]),
            .d       (in_data),
            .q       (shadow[i])
        );
        op2_gather_slot #(.DATA_W(DATA_W)) u_out (
            .clock   (clock),
            .reset_n (reset_n),
            .load    (copy),
            .d       (wr_sel[i] ? in_data : shadow[i]),
            .q       (obank[i])
        );
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count  <= 4'd0;
            ovalid <= 1'b0;
            sfull  <= 1'b0;
        end else if (clear) begin
            count  <= 4'd0;
            ovalid <= 1'b0;
            sfull  <= 1'b0;
        end else begin
            if (in_xfer) count <= count + 4'd1;  // wraps to 0 after slot 15
            if (copy)          ovalid <= 1'b1;
            else if (out_xfer) ovalid <= 1'b0;
            if (last_in && ovalid && !out_xfer) sfull <= 1'b1;
            else if (out_xfer)                  sfull <= 1'b0;
        end
    end

    assign in_ready   = !sfull;
    assign out_valid  = ovalid;
    assign data_out   = obank;
    assign fill_level = sfull ? 5'd16 : {1'b0, count};

`else

    localparam logic [0:0] S_FILL = 1'b0;
    localparam logic [0:0] S_HOLD = 1'b1;

    logic [0:0]                 state;
    logic [NUM-1:0][DATA_W-1:0] bank;

    // Slots are written in place, so partial frames show on data_out.
    for (genvar i = 0; i < NUM; i++) begin : g_lane
        op2_gather_slot #(.DATA_W(DATA_W)) u_slot (
            .clock   (clock),
            .reset_n (reset_n),
            .load    (wr_sel[i]),
            .d       (in_data),
            .q       (bank[i])
        );
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_FILL;
            count <= 4'd0;
        end else if (clear) begin
            state <= S_FILL;
            count <= 4'd0;
        end else begin
            case (state)
                S_FILL: if (in_xfer) begin
                    count <= count + 4'd1;  // wraps to 0 after slot 15
                    if (last_in) state <= S_HOLD;
                end
                default: if (out_xfer) state <= S_FILL;
            endcase
        end
    end

    assign in_ready   = (state == S_FILL);
    assign out_valid  = (state == S_HOLD);
    assign data_out   = bank;
    assign fill_level = (state == S_HOLD) ? 5'd16 : {1'b0, count};

`endif

endmodule

// File: tb/tb_op2_gather.sv
module tb_op2_gather;
    localparam int DW = 12;
    localparam int N  = 16;
    localparam int FW = DW * N;
`ifdef OP2_GATHER_DBUF_EN
    localparam int CAP = 2;   // frames the block can hold at once
`else
    localparam int CAP = 1;
`endif

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [FW-1:0] data_out;
    logic [4:0]    fill_level;

    op2_gather dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .data_out   (data_out),
        .fill_level (fill_level)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: queue of complete frames awaiting output + partial frame.
    logic [FW-1:0] frames[$];
    logic [FW-1:0] part = '0;
    int            pcnt = 0;
    int            frames_out = 0;
    int            dut_acc = 0;

    task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag);
        chk({tag, ":out_valid"}, FW'(out_valid), FW'(frames.size() > 0));
        chk({tag, ":in_ready"}, FW'(in_ready), FW'(frames.size() < CAP));
        chk({tag, ":fill_level"}, FW'(fill_level),
            (frames.size() >= CAP) ? FW'(16) : FW'(pcnt));
        if (frames.size() > 0) chk({tag, ":data_out"}, data_out, frames[0]);
    endtask

    // Apply current inputs across one rising edge, advance the model, check.
    task automatic step(input string tag);
        bit acc, take;
        acc  = in_valid && (frames.size() < CAP);
        take = out_ready && (frames.size() > 0);
        if (in_valid && in_ready) dut_acc++;
        @(posedge clock);
        if (clear) begin
            frames.delete();
            pcnt = 0;
        end else begin
            if (take) begin
                void'(frames.pop_front());
                frames_out++;
            end
            if (acc) begin
                part[DW*pcnt +: DW] = in_data;
                pcnt++;
                if (pcnt == N) begin
                    frames.push_back(part);
                    pcnt = 0;
                end
            end
        end
        #1;
        check_outs(tag);
    endtask

    initial begin
        logic [DW-1:0] first_word;
        int start_out;
        int guard;

        // Reset state
        #12;
        chk("rst:out_valid", FW'(out_valid), FW'(0));
        chk("rst:data_out", data_out, '0);
        chk("rst:fill_level", FW'(fill_level), FW'(0));
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check_outs("rst_rel");

        // Directed frame 0x001..0x010, downstream stalled
        out_ready = 1'b0;
        for (int k = 1; k <= N; k++) begin
            in_valid = 1'b1;
            in_data  = DW'(k);
            step("fill");
        end
        chk("fill:slot0", FW'(data_out[DW-1:0]), FW'(12'h001));
        chk("fill:slot15", FW'(data_out[FW-1 -: DW]), FW'(12'h010));
        chk("fill:fill_level", FW'(fill_level), FW'(16));
        chk("fill:out_valid", FW'(out_valid), FW'(1));

        // Stall 10 cycles with input offered, then single-cycle out_ready
        for (int k = 0; k < 10; k++) begin
            in_data = DW'($urandom);
            step("hold");
        end
        out_ready = 1'b1;
        step("pulse");
        out_ready = 1'b0;
        chk("pulse:out_valid", FW'(out_valid), FW'(0));
        chk("pulse:in_ready", FW'(in_ready), FW'(1));

        // Clear mid-frame: start from an empty block first
        in_valid = 1'b0;
        clear = 1'b1;
        step("pre_clear");
        clear = 1'b0;
        for (int k = 0; k < 7; k++) begin
            in_valid = 1'b1;
            in_data  = DW'($urandom);
            step("part");
        end
        clear   = 1'b1;
        in_data = 12'hABC;
        step("clear");
        clear = 1'b0;
        chk("clear:fill_level", FW'(fill_level), FW'(0));
        first_word = 12'h5A5;
        for (int k = 0; k < N; k++) begin
            in_data = (k == 0) ? first_word : DW'($urandom);
            step("after_clear");
        end
        chk("after_clear:slot0", FW'(data_out[DW-1:0]), FW'(first_word));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) step("drain");

        // Random traffic, 1000 frames in order
        start_out = frames_out;
        guard = 0;
        while ((frames_out - start_out) < 1000 && guard < 60000) begin
            in_valid  = ($urandom_range(0, 7) != 0);
            in_data   = DW'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step("rand");
            guard++;
        end
        chk("rand:frames", FW'(frames_out - start_out), FW'(1000));

        // Async reset while holding a frame
        in_valid  = 1'b0;
        out_ready = 1'b0;
        clear = 1'b1;
        step("pre_arst");
        clear = 1'b0;
        for (int k = 0; k < N; k++) begin
            in_valid = 1'b1;
            in_data  = DW'($urandom);
            step("arst_fill");
        end
        in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst:out_valid", FW'(out_valid), FW'(0));
        chk("arst:data_out", data_out, '0);
        chk("arst:fill_level", FW'(fill_level), FW'(0));
        frames.delete();
        pcnt = 0;
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check_outs("arst_rel");

`ifdef OP2_GATHER_DBUF_EN
        // Continuous streaming: a frame every 16 cycles
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 17; k++) begin
            in_data = DW'($urandom);
            step("stream_warm");
        end
        start_out = frames_out;
        for (int k = 0; k < 160; k++) begin
            in_data = DW'($urandom);
            step("stream");
        end
        chk("stream:frames", FW'(frames_out - start_out), FW'(10));

        // Stalled output: both banks fill, exactly 32 words accepted
        in_valid = 1'b0;
        clear = 1'b1;
        step("pre_cap");
        clear = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        dut_acc = 0;
        for (int k = 0; k < 40; k++) begin
            in_data = DW'($urandom);
            step("cap");
        end
        chk("cap:accepted", FW'(dut_acc), FW'(32));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
